// File: rtl/d_ffec.sv
`default_nettype none
// ============================================================================
// Module   : d_ffec
// Purpose  : Edge-triggered D register with clock enable, asynchronous clear,
//            and true plus complementary outputs.
// Revision : 1.0  initial release
// ============================================================================
module d_ffec #(
  parameter int WIDTH = 1
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic [WIDTH-1:0] D,
  input  logic             En,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (En) begin
      q_d = D;
    end
  end

  // Clrn is active-high despite its name; it overrides En, D and Clk.
  always_ff @(posedge Clk or posedge Clrn) begin
    if (Clrn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q  = q_q;
  assign Qn = ~q_q;

endmodule
`default_nettype wire

// File: tb/tb_d_ffec.sv
`default_nettype none
// Self-checking bench for d_ffec: directed scenarios plus randomized traffic
// on a 1-bit and an 8-bit instance against a simple behavioural model.
module tb_d_ffec;

  logic       clk  = 1'b0;
  logic       clrn = 1'b1;
  logic       en   = 1'b0;
  logic [7:0] d8   = 8'h00;
  logic       d1   = 1'b0;
  logic [7:0] q8, qn8;
  logic       q1, qn1;

  logic [7:0] m8;
  logic       m1;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #10 clk = ~clk;

  d_ffec #(.WIDTH(8)) u_dut8 (
    .Clk (clk), .Clrn(clrn), .D(d8), .En(en), .Q(q8), .Qn(qn8)
  );

  d_ffec #(.WIDTH(1)) u_dut1 (
    .Clk (clk), .Clrn(clrn), .D(d1), .En(en), .Q(q1), .Qn(qn1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".q8"},  q8,  m8);
    chk({tag, ".qn8"}, qn8, ~m8);
    chk({tag, ".q1"},  {7'b0, q1},  {7'b0, m1});
    chk({tag, ".qn1"}, {7'b0, qn1}, {7'b0, ~m1});
  endtask

  // Drive inputs mid-cycle (negedge), then evaluate the following rising edge.
  // A clear raised here must take effect before that edge.
  task automatic step(input string tag, input logic [7:0] dv8, input logic dv1,
                      input logic env, input logic clr);
    @(negedge clk);
    d8 = dv8; d1 = dv1; en = env; clrn = clr;
    if (clr) begin
      m8 = 8'h00; m1 = 1'b0;
      #1 chk_all({tag, ".async"});
    end
    @(posedge clk);
    #1;
    if (clrn) begin
      m8 = 8'h00; m1 = 1'b0;
    end else if (en) begin
      m8 = d8; m1 = d1;
    end
    chk_all(tag);
  endtask

  initial begin
    m8 = 8'h00; m1 = 1'b0;
    #1 chk_all("por_clear");

    // Clear held: edges, D=1 and En=1 are all ignored.
    for (int i = 0; i < 3; i++) step("clr_hold", 8'hFF, 1'b1, 1'b1, 1'b1);

    // Release clear; Q must stay 0 through edges with En=0.
    step("hold0_a", 8'h00, 1'b0, 1'b0, 1'b0);
    step("hold0_b", 8'hFF, 1'b1, 1'b0, 1'b0);
    step("hold0_c", 8'h00, 1'b0, 1'b0, 1'b0);

    // Capture sequence 1,0,1.
    step("cap1", 8'hFF, 1'b1, 1'b1, 1'b0);
    step("cap0", 8'h00, 1'b0, 1'b1, 1'b0);
    step("cap1b", 8'hFF, 1'b1, 1'b1, 1'b0);

    // Mid-cycle clear while Q=1, held across one edge, then released.
    step("clr_pulse", 8'hFF, 1'b1, 1'b1, 1'b1);
    step("clr_rel", 8'hFF, 1'b1, 1'b1, 1'b0);

    // D glitch between edges must not be captured.
    step("pre_glitch", 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    d8 = 8'hFF; d1 = 1'b1;
    #4 d8 = 8'h00; d1 = 1'b0;
    @(posedge clk);
    #1 chk_all("glitch");

    // Byte-wide capture then hold.
    step("a5", 8'hA5, 1'b1, 1'b1, 1'b0);
    step("hold_3c", 8'h3C, 1'b0, 1'b0, 1'b0);
    step("hold_3c2", 8'h3C, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 300; i++) begin
      step("rand", 8'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
